panel_key_debounce: RTL and testbench

Front-panel key conditioner for the console switch and key inputs. It synchronizes N raw, bouncing, asynchronous key levels into `clk`, then debounces each one with a per-key stability counter. For every key it produces a clean level plus one-cycle press and release pulses. It sits directly upstream of the pulse-generator/delay-chain logic, so console keys such as START, STOP, EXAMINE and DEPOSIT reach it as clean single pulses.

---
 rtl/panel_pkg.sv | 24 ++
 rtl/panel_key_chan.sv | 106 ++++++++++
 rtl/panel_key_debounce.sv | 44 ++++
 tb/tb_panel_key_debounce.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared constants, channel event payload and counter-width helper for the
// front-panel key conditioner.
package panel_pkg;

    localparam int unsigned DEB_CYCLES_DEF = 100000;    // 1 ms at 10 ns
    localparam int unsigned REP_DELAY_DEF  = 50000000;  // 0.5 s
    localparam int unsigned REP_PERIOD_DEF = 10000000;  // 0.1 s
    localparam int unsigned DEB_CYCLES_MAX = 1 << 20;

    typedef struct packed {
        logic lvl;
        logic press;
        logic rel;
    } key_evt_t;

    // Bits needed to hold the values 0..v, i.e. ceil(log2(v+1)), minimum 1.
    function automatic int unsigned cnt_width(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(v)) w++;
        return w;
    endfunction

endpackage

// File: rtl/panel_key_chan.sv
// One key channel: 2-flop synchronizer, stability-counter debounce, edge pulses
// and, with PANEL_KEY_REPEAT_EN defined, an auto-repeat timer.
module panel_key_chan
    import panel_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     key_raw,
`ifdef PANEL_KEY_REPEAT_EN
    input  logic     rep_sw,
`endif
    output key_evt_t evt
);

    localparam int unsigned   CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    if (DEB_CYCLES == 0 || DEB_CYCLES > DEB_CYCLES_MAX ||
        REP_DELAY == 0 || REP_PERIOD == 0) begin : g_bad_param
        $error("panel_key_chan: timing parameter out of range");
    end

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          rep_fire;
    logic          press_q;
    logic          rel_q;

    assign accept = (s2 != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    // Any return of s2 to the stable level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (accept) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef PANEL_KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned RW      = cnt_width(REP_MAX);

    logic [RW-1:0] rep_cnt;
    logic          rep_first;
    logic          rep_run;

    // Timer only sees stable=1 from the cycle after the accepted press.
    assign rep_run  = stable && rep_sw;
    assign rep_fire = rep_run &&
        (rep_cnt == (rep_first ? RW'(REP_PERIOD - 1) : RW'(REP_DELAY - 1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (!rep_run) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            press_q <= (accept && s2) || rep_fire;
            rel_q   <= accept && !s2;
        end
    end

    assign evt = key_evt_t'{lvl: stable, press: press_q, rel: rel_q};

endmodule

// File: rtl/panel_key_debounce.sv
// Front-panel key conditioner: N independent debounced key channels.
// Define PANEL_KEY_REPEAT_EN to add the rep_sw port and auto-repeat presses.
module panel_key_debounce
    import panel_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] key_raw,
`ifdef PANEL_KEY_REPEAT_EN
    input  logic         rep_sw,
`endif
    output logic [N-1:0] key_lvl,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release
);

    for (genvar i = 0; i < int'(N); i++) begin : g_chan
        key_evt_t evt;

        panel_key_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .key_raw (key_raw[i]),
`ifdef PANEL_KEY_REPEAT_EN
            .rep_sw  (rep_sw),
`endif
            .evt     (evt)
        );

        assign key_lvl[i]     = evt.lvl;
        assign key_press[i]   = evt.press;
        assign key_release[i] = evt.rel;
    end

endmodule

// File: tb/tb_panel_key_debounce.sv
// Scoreboard bench for panel_key_debounce with DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=6.
module tb_panel_key_debounce;

    localparam int unsigned N   = 8;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 6;
    localparam int          LAT = int'(DEB) + 2;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] key_raw;
`ifdef PANEL_KEY_REPEAT_EN
    logic         rep_sw;
`endif
    logic [N-1:0] key_lvl;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;

    int           cyc   = 0;
    int           tests = 0;
    int           fails = 0;
    logic [N-1:0] exp_lvl;
    exp_t         exp_q[$];
    exp_t         mon_e;

    panel_key_debounce #(
        .N          (N),
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_raw),
`ifdef PANEL_KEY_REPEAT_EN
        .rep_sw      (rep_sw),
`endif
        .key_lvl     (key_lvl),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulses are matched in order against the expected-event queue.
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL missed_event: nothing at cycle %0d, expected press=%b release=%b",
                     exp_q[0].cyc, exp_q[0].press, exp_q[0].rel);
            void'(exp_q.pop_front());
        end
        if ((key_press | key_release) != '0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got press=%b release=%b at cycle %0d, expected none",
                         key_press, key_release, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc !== cyc || mon_e.press !== key_press || mon_e.rel !== key_release) begin
                    fails++;
                    $display("FAIL event: got press=%b release=%b at cycle %0d, expected press=%b release=%b at cycle %0d",
                             key_press, key_release, cyc, mon_e.press, mon_e.rel, mon_e.cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input int at, input logic [N-1:0] p, input logic [N-1:0] r);
        exp_t e;
        e.cyc   = at;
        e.press = p;
        e.rel   = r;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        step(1);
        tests++;
        if (key_lvl !== 8'h00 || key_press !== 8'h00 || key_release !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got lvl=%b press=%b release=%b, expected all zero",
                     key_lvl, key_press, key_release);
        end
        reset = 1'b0;
        step(3);
        tests++;
        if (key_lvl !== 8'h00) begin
            fails++;
            $display("FAIL reset_idle: got lvl=%b, expected %b", key_lvl, 8'h00);
        end
    endtask

    task automatic test_clean_press();
        key_raw[0] = 1'b1;
        expect_evt(cyc + LAT, 8'h01, 8'h00);
        step(LAT - 1);
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL clean_press_early: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        step(1);
        exp_lvl[0] = 1'b1;
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL clean_press_lvl: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        step(3);
        key_raw[0] = 1'b0;
        expect_evt(cyc + LAT, 8'h00, 8'h01);
        step(LAT + 2);
        exp_lvl[0] = 1'b0;
        tests++;
        if (key_lvl !== exp_lvl || exp_q.size() != 0) begin
            fails++;
            $display("FAIL clean_release: got lvl=%b pending=%0d, expected lvl=%b pending=0",
                     key_lvl, exp_q.size(), exp_lvl);
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        key_raw[2] = 1'b1;
        step(3);
        key_raw[2] = 1'b0;
        step(1);
        key_raw[2] = 1'b1;
        expect_evt(cyc + LAT, 8'h04, 8'h00);
        step(LAT - 1);
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL bounce_early: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        step(3);
        exp_lvl[2] = 1'b1;
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL bounce_lvl: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        key_raw[2] = 1'b0;
        expect_evt(cyc + LAT, 8'h00, 8'h04);
        step(LAT + 2);
        exp_lvl[2] = 1'b0;
        tests++;
        if (key_lvl !== exp_lvl || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bounce_release: got lvl=%b pending=%0d, expected lvl=%b pending=0",
                     key_lvl, exp_q.size(), exp_lvl);
            exp_q.delete();
        end
    endtask

    task automatic test_glitch();
        int c0;
        key_raw[5] = 1'b1;
        step(2);
        key_raw[5] = 1'b0;
        step(LAT + 4);
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL glitch_lvl: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        // A pulse exactly DEB_CYCLES long is accepted, release follows DEB_CYCLES later.
        c0 = cyc;
        key_raw[5] = 1'b1;
        expect_evt(c0 + LAT, 8'h20, 8'h00);
        step(int'(DEB));
        key_raw[5] = 1'b0;
        expect_evt(c0 + int'(DEB) + LAT, 8'h00, 8'h20);
        step(LAT + 2);
        tests++;
        if (key_lvl !== exp_lvl || exp_q.size() != 0) begin
            fails++;
            $display("FAIL min_width: got lvl=%b pending=%0d, expected lvl=%b pending=0",
                     key_lvl, exp_q.size(), exp_lvl);
            exp_q.delete();
        end
    endtask

    task automatic test_simultaneous();
        key_raw = key_raw | 8'h82;
        expect_evt(cyc + LAT, 8'h82, 8'h00);
        step(LAT + 2);
        exp_lvl = exp_lvl | 8'h82;
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL simul_press: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        key_raw[1] = 1'b0;
        expect_evt(cyc + LAT, 8'h00, 8'h02);
        step(LAT + 2);
        exp_lvl[1] = 1'b0;
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL simul_release1: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        key_raw[7] = 1'b0;
        expect_evt(cyc + LAT, 8'h00, 8'h80);
        step(LAT + 2);
        exp_lvl[7] = 1'b0;
        tests++;
        if (key_lvl !== exp_lvl || exp_q.size() != 0) begin
            fails++;
            $display("FAIL simul_release7: got lvl=%b pending=%0d, expected lvl=%b pending=0",
                     key_lvl, exp_q.size(), exp_lvl);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        key_raw[6] = 1'b1;
        expect_evt(cyc + LAT, 8'h40, 8'h00);
        step(LAT + 1);
        exp_lvl[6] = 1'b1;
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL rst_mid_pre: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        key_raw[3] = 1'b1;
        step(4);
        reset = 1'b1;
        exp_lvl = 8'h00;
        #1;
        tests++;
        if (key_lvl !== 8'h00 || key_press !== 8'h00 || key_release !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid_clear: got lvl=%b press=%b release=%b, expected all zero",
                     key_lvl, key_press, key_release);
        end
        step(2);
        reset = 1'b0;
        expect_evt(cyc + LAT, 8'h48, 8'h00);
        step(LAT - 1);
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL rst_mid_early: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        step(3);
        exp_lvl = 8'h48;
        tests++;
        if (key_lvl !== exp_lvl) begin
            fails++;
            $display("FAIL rst_mid_accept: got lvl=%b, expected %b", key_lvl, exp_lvl);
        end
        key_raw = key_raw & ~8'h48;
        expect_evt(cyc + LAT, 8'h00, 8'h48);
        step(LAT + 2);
        exp_lvl = 8'h00;
        tests++;
        if (key_lvl !== exp_lvl || exp_q.size() != 0) begin
            fails++;
            $display("FAIL rst_mid_release: got lvl=%b pending=%0d, expected lvl=%b pending=0",
                     key_lvl, exp_q.size(), exp_lvl);
            exp_q.delete();
        end
    endtask

`ifdef PANEL_KEY_REPEAT_EN
    task automatic test_repeat();
        int a;
        rep_sw = 1'b1;
        key_raw[4] = 1'b1;
        a = cyc + LAT;
        expect_evt(a, 8'h10, 8'h00);
        expect_evt(a + int'(RD), 8'h10, 8'h00);
        expect_evt(a + int'(RD) + int'(RP), 8'h10, 8'h00);
        expect_evt(a + int'(RD) + 2 * int'(RP), 8'h10, 8'h00);
        expect_evt(a + int'(RD) + 3 * int'(RP), 8'h10, 8'h00);
        step(40);
        key_raw[4] = 1'b0;
        expect_evt(cyc + LAT, 8'h00, 8'h10);
        step(LAT + 2);
        tests++;
        if (key_lvl !== exp_lvl || exp_q.size() != 0) begin
            fails++;
            $display("FAIL repeat_run: got lvl=%b pending=%0d, expected lvl=%b pending=0",
                     key_lvl, exp_q.size(), exp_lvl);
            exp_q.delete();
        end
        key_raw[4] = 1'b1;
        a = cyc + LAT;
        expect_evt(a, 8'h10, 8'h00);
        expect_evt(a + int'(RD), 8'h10, 8'h00);
        expect_evt(a + int'(RD) + int'(RP), 8'h10, 8'h00);
        step(LAT + 30);
        rep_sw = 1'b0;
        step(4);
        key_raw[4] = 1'b0;
        expect_evt(cyc + LAT, 8'h00, 8'h10);
        step(LAT + 2);
        rep_sw = 1'b1;
        tests++;
        if (key_lvl !== exp_lvl || exp_q.size() != 0) begin
            fails++;
            $display("FAIL repeat_sw_drop: got lvl=%b pending=%0d, expected lvl=%b pending=0",
                     key_lvl, exp_q.size(), exp_lvl);
            exp_q.delete();
        end
    endtask
`else
    // Without auto-repeat a long hold yields exactly one press and one release.
    task automatic test_repeat();
        key_raw[4] = 1'b1;
        expect_evt(cyc + LAT, 8'h10, 8'h00);
        step(40);
        tests++;
        if (key_lvl !== (exp_lvl | 8'h10)) begin
            fails++;
            $display("FAIL long_hold_lvl: got lvl=%b, expected %b", key_lvl, exp_lvl | 8'h10);
        end
        key_raw[4] = 1'b0;
        expect_evt(cyc + LAT, 8'h00, 8'h10);
        step(LAT + 2);
        tests++;
        if (key_lvl !== exp_lvl || exp_q.size() != 0) begin
            fails++;
            $display("FAIL long_hold: got lvl=%b pending=%0d, expected lvl=%b pending=0",
                     key_lvl, exp_q.size(), exp_lvl);
            exp_q.delete();
        end
    endtask
`endif

    initial begin
        reset   = 1'b0;
        key_raw = '0;
        exp_lvl = '0;
`ifdef PANEL_KEY_REPEAT_EN
        rep_sw  = 1'b0;
`endif
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        step(4);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL final_drain: got %0d pending events, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
